io_bus_target: RTL and testbench

- Downstream target of the CPU byte-bus master.
- Decodes the toggle-handshake byte stream: header, segment, addr hi, addr lo, then data bytes in or out.
- Converts each transaction into byte-wide memory accesses and returns read bytes on the same bus.
- Sits between the CPU-side bus master and the memory/peripheral fabric.

---
 rtl/io_bus_target_pkg.sv | 23 ++
 rtl/io_bus_target_hdr_decode.sv | 37 +++
 rtl/io_bus_target.sv | 171 +++++++++++++++++
 tb/tb_io_bus_target.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_bus_target_pkg.sv
// Shared definitions for the CPU byte-bus target and master.
package io_bus_target_pkg;

  // Header bit positions
  localparam int unsigned HDR_LS = 7;
  localparam int unsigned HDR_W  = 6;
  localparam int unsigned HDR_IL = 5;
  localparam int unsigned HDR_CS = 2;
  localparam int unsigned HDR_DS = 1;
  localparam int unsigned HDR_SS = 0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEG     = 3'd1,
    ST_AHI     = 3'd2,
    ST_ALO     = 3'd3,
    ST_RD_REQ  = 3'd4,
    ST_RD_WAIT = 3'd5,
    ST_WR_WAIT = 3'd6,
    ST_WR_REQ  = 3'd7
  } state_t;

endpackage

// File: rtl/io_bus_target_hdr_decode.sv
// Combinational header decode: direction, memory access count, bus data beats, segment select.
module io_bus_hdr_decode
  import io_bus_target_pkg::*;
#(
  parameter int unsigned IL_BYTES = 4
) (
  input  logic [7:0] hdr,
  output logic       is_write,
  output logic [7:0] len,
  output logic [7:0] beats,
  output logic [2:0] seg_sel
);

  localparam logic [7:0] IL_LEN = 8'(IL_BYTES);

  // Reserved header bits carry no meaning.
  logic unused_rsvd;
  assign unused_rsvd = ^hdr[4:3];

  assign seg_sel = {hdr[HDR_CS], hdr[HDR_DS], hdr[HDR_SS]};

  // Instruction load wins over store; otherwise byte vs word sets the access count.
  // Non-IL transfers always move two data beats on the bus so toggle counts stay even.
  always_comb begin
    is_write = 1'b0;
    len      = 8'd2;
    beats    = 8'd2;
    if (hdr[HDR_IL]) begin
      len   = IL_LEN;
      beats = IL_LEN;
    end else begin
      is_write = hdr[HDR_LS];
      len      = hdr[HDR_W] ? 8'd1 : 8'd2;
    end
  end

endmodule

// File: rtl/io_bus_target.sv
// Byte-bus target: decodes header/segment/address bytes and runs byte-wide memory accesses.
module io_bus_target
  import io_bus_target_pkg::*;
#(
  parameter int unsigned IL_BYTES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bus_sync_in,
  input  logic [7:0]  bus_data_in,
  output logic        bus_sync_out,
  output logic [7:0]  bus_data_out,
  output logic        mem_req,
  output logic        mem_we,
  output logic [2:0]  mem_seg_sel,
  output logic [23:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic        busy
);

  state_t      state, state_nxt;
  logic [7:0]  hdr_q, seg_q, ahi_q, alo_q, idx_q;
  logic        first_q;
  logic        is_write;
  logic [7:0]  len, beats;
  logic [15:0] offset;
  logic        pend, more, rd_due_next, wr_due;
  logic        ack, ld_hdr, ld_seg, ld_ahi, ld_alo, ld_rdata, ld_wdata, idx_inc;
  logic        busy_set, busy_clr, first_set, first_clr;

  io_bus_hdr_decode #(.IL_BYTES(IL_BYTES)) u_hdr_decode (
    .hdr      (hdr_q),
    .is_write (is_write),
    .len      (len),
    .beats    (beats),
    .seg_sel  (mem_seg_sel)
  );

  assign pend        = bus_sync_in != bus_sync_out;
  assign more        = ({1'b0, idx_q} + 9'd1) < {1'b0, beats};
  assign rd_due_next = ({1'b0, idx_q} + 9'd1) < {1'b0, len};
  assign wr_due      = idx_q < len;
  assign offset      = {ahi_q, alo_q} + {8'h00, idx_q};
  assign mem_addr    = {seg_q, offset};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state, memory strobes and datapath controls.
  // Beats beyond the access count (byte accesses) are acked without touching memory.
  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    ack       = 1'b0;
    ld_hdr    = 1'b0;
    ld_seg    = 1'b0;
    ld_ahi    = 1'b0;
    ld_alo    = 1'b0;
    ld_rdata  = 1'b0;
    ld_wdata  = 1'b0;
    idx_inc   = 1'b0;
    busy_set  = 1'b0;
    busy_clr  = 1'b0;
    first_set = 1'b0;
    first_clr = 1'b0;
    case (state)
      ST_IDLE: if (pend) begin
        ld_hdr = 1'b1; ack = 1'b1; busy_set = 1'b1; state_nxt = ST_SEG;
      end
      ST_SEG: if (pend) begin
        ld_seg = 1'b1; ack = 1'b1; state_nxt = ST_AHI;
      end
      ST_AHI: if (pend) begin
        ld_ahi = 1'b1; ack = 1'b1; state_nxt = ST_ALO;
      end
      ST_ALO: if (pend) begin
        ld_alo = 1'b1;
        if (is_write) begin
          first_set = 1'b1; state_nxt = ST_WR_WAIT;
        end else begin
          state_nxt = ST_RD_REQ;
        end
      end
      ST_RD_REQ: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ld_rdata = 1'b1; ack = 1'b1; state_nxt = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: if (pend) begin
        if (more) begin
          idx_inc = 1'b1;
          if (rd_due_next) state_nxt = ST_RD_REQ;
          else             ack = 1'b1;
        end else begin
          ack = 1'b1; busy_clr = 1'b1; state_nxt = ST_IDLE;
        end
      end
      ST_WR_WAIT: begin
        if (first_q) begin
          ack = 1'b1; first_clr = 1'b1;
        end else if (pend) begin
          if (wr_due) begin
            ld_wdata = 1'b1; state_nxt = ST_WR_REQ;
          end else begin
            ack = 1'b1;
            if (more) idx_inc = 1'b1;
            else begin
              busy_clr = 1'b1; state_nxt = ST_IDLE;
            end
          end
        end
      end
      ST_WR_REQ: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ack) begin
          ack = 1'b1;
          if (more) begin
            idx_inc = 1'b1; state_nxt = ST_WR_WAIT;
          end else begin
            busy_clr = 1'b1; state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Datapath registers: latched bus fields, beat index, ack strobe, busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_q        <= '0;
      seg_q        <= '0;
      ahi_q        <= '0;
      alo_q        <= '0;
      idx_q        <= '0;
      first_q      <= 1'b0;
      bus_sync_out <= 1'b0;
      bus_data_out <= '0;
      mem_wdata    <= '0;
      busy         <= 1'b0;
    end else begin
      if (ack)      bus_sync_out <= bus_sync_in;
      if (ld_hdr) begin
        hdr_q <= bus_data_in;
        idx_q <= '0;
      end
      if (ld_seg)   seg_q <= bus_data_in;
      if (ld_ahi)   ahi_q <= bus_data_in;
      if (ld_alo) begin
        alo_q <= bus_data_in;
        idx_q <= '0;
      end
      if (idx_inc)  idx_q <= idx_q + 8'd1;
      if (ld_rdata) bus_data_out <= mem_rdata;
      if (ld_wdata) mem_wdata <= bus_data_in;
      if (busy_set)      busy <= 1'b1;
      else if (busy_clr) busy <= 1'b0;
      if (first_set)      first_q <= 1'b1;
      else if (first_clr) first_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_io_bus_target.sv
// Randomised scoreboard bench for io_bus_target: bench acts as bus master and memory.
module tb_io_bus_target;

  localparam int unsigned IL = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bus_sync_in = 1'b0;
  logic [7:0]  bus_data_in = '0;
  logic        bus_sync_out;
  logic [7:0]  bus_data_out;
  logic        mem_req, mem_we;
  logic [2:0]  mem_seg_sel;
  logic [23:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        busy;

  io_bus_target #(.IL_BYTES(IL)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus_sync_in  (bus_sync_in),
    .bus_data_in  (bus_data_in),
    .bus_sync_out (bus_sync_out),
    .bus_data_out (bus_data_out),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_seg_sel  (mem_seg_sel),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       chk;
    logic [7:0] data;
    logic       busy;
  } bus_exp_t;

  typedef struct {
    logic        we;
    logic [2:0]  sel;
    logic [23:0] addr;
    logic [7:0]  wdata;
  } mem_exp_t;

  bus_exp_t   exp_bus[$];
  mem_exp_t   exp_mem[$];
  logic [7:0] mem_arr [logic [23:0]];
  logic [7:0] ref_mem [logic [23:0]];

  int checks = 0;
  int errors = 0;
  int mem_delay_fix = -1;
  int last_req_len = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] init_byte(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5C;
  endfunction

  function automatic logic [7:0] ref_get(input logic [23:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction

  function automatic logic [7:0] mem_get(input logic [23:0] a);
    return mem_arr.exists(a) ? mem_arr[a] : init_byte(a);
  endfunction

  task automatic preload(input logic [23:0] a, input logic [7:0] v);
    mem_arr[a] = v;
    ref_mem[a] = v;
  endtask

  // Memory responder: acks each request after a fixed or random delay
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && mem_req) begin
        int d;
        bit abort;
        d = (mem_delay_fix >= 0) ? mem_delay_fix : int'($urandom_range(3, 0));
        abort = 1'b0;
        for (int k = 0; k < d; k++) begin
          @(negedge clk);
          if (!rst_n) begin
            abort = 1'b1;
            break;
          end
        end
        if (!abort && rst_n && mem_req) begin
          if (mem_we) mem_arr[mem_addr] = mem_wdata;
          else        mem_rdata = mem_get(mem_addr);
          mem_ack = 1'b1;
          @(negedge clk);
          mem_ack = 1'b0;
        end
      end
    end
  end

  // Memory-side monitor: each new request is matched against the scoreboard
  initial begin
    bit          active;
    int          req_len;
    logic [43:0] cap;
    mem_exp_t    e;
    active = 1'b0;
    req_len = 0;
    cap = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        active = 1'b0;
      end else if (mem_req) begin
        if (!active) begin
          active = 1'b1;
          req_len = 1;
          cap = {mem_we, mem_seg_sel, mem_addr, mem_wdata};
          if (exp_mem.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL mem_req_unexpected actual addr=%0h we=%0b required no request", mem_addr, mem_we);
          end else begin
            e = exp_mem.pop_front();
            chk("mem_req", {mem_we, mem_seg_sel, mem_addr, (mem_we ? mem_wdata : 8'h00)},
                {e.we, e.sel, e.addr, (e.we ? e.wdata : 8'h00)});
          end
        end else begin
          req_len++;
          chk("mem_stable", {mem_we, mem_seg_sel, mem_addr, mem_wdata}, cap);
        end
      end else if (active) begin
        active = 1'b0;
        last_req_len = req_len;
      end
    end
  end

  // Bus-side monitor: every ack edge is matched against the scoreboard
  initial begin
    logic     prev;
    bus_exp_t b;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = 1'b0;
      end else if (bus_sync_out !== prev) begin
        prev = bus_sync_out;
        if (exp_bus.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL bus_ack_unexpected actual extra ack data=%0h required no ack", bus_data_out);
        end else begin
          b = exp_bus.pop_front();
          chk("ack_busy", busy, b.busy);
          if (b.chk) chk("rd_data", bus_data_out, b.data);
        end
      end
    end
  end

  task automatic push_bus(input logic c, input logic [7:0] d, input logic bz);
    exp_bus.push_back('{chk: c, data: d, busy: bz});
  endtask

  task automatic toggle(input logic [7:0] b);
    @(posedge clk);
    #1;
    bus_data_in = b;
    bus_sync_in = ~bus_sync_in;
  endtask

  task automatic wait_ack(input string name);
    int c;
    c = 0;
    while (bus_sync_out !== bus_sync_in && c < 200) begin
      @(posedge clk);
      #1;
      c++;
    end
    if (bus_sync_out !== bus_sync_in) chk({name, "_timeout"}, bus_sync_out, bus_sync_in);
  endtask

  task automatic send_fast(input logic [7:0] b, input string name);
    toggle(b);
    @(posedge clk);
    #1;
    chk({name, "_latency"}, bus_sync_out, bus_sync_in);
    wait_ack(name);
  endtask

  // One full transaction: expectations derived from the header rules, then driven
  task automatic run_txn(input logic [7:0] hdr, input logic [7:0] seg, input logic [15:0] addr,
                         input logic [7:0] wd0, input logic [7:0] wd1);
    bit          il, ls, w, wr;
    int          n, beats;
    logic [7:0]  rd[$];
    logic [7:0]  wd;
    logic [23:0] a;
    il = hdr[5];
    ls = hdr[7];
    w  = hdr[6];
    wr = !il && ls;
    n  = il ? int'(IL) : (w ? 1 : 2);
    beats = il ? int'(IL) : 2;
    for (int k = 0; k < 3; k++) push_bus(1'b0, 8'h00, 1'b1);
    if (!wr) begin
      for (int k = 0; k < n; k++) begin
        a = {seg, 16'(addr + 16'(k))};
        rd.push_back(ref_get(a));
        exp_mem.push_back('{we: 1'b0, sel: hdr[2:0], addr: a, wdata: 8'h00});
      end
      for (int k = 0; k < beats; k++) push_bus(1'b1, rd[(k < n) ? k : n - 1], 1'b1);
      push_bus(1'b1, rd[n - 1], 1'b0);
    end else begin
      push_bus(1'b0, 8'h00, 1'b1);
      for (int k = 0; k < beats; k++) begin
        wd = (k == 0) ? wd0 : wd1;
        if (k < n) begin
          a = {seg, 16'(addr + 16'(k))};
          exp_mem.push_back('{we: 1'b1, sel: hdr[2:0], addr: a, wdata: wd});
          ref_mem[a] = wd;
        end
        push_bus(1'b0, 8'h00, (k == beats - 1) ? 1'b0 : 1'b1);
      end
    end
    send_fast(hdr, "hdr");
    send_fast(seg, "seg");
    send_fast(addr[15:8], "ahi");
    toggle(addr[7:0]);
    wait_ack("alo");
    for (int k = 0; k < beats; k++) begin
      toggle(wr ? ((k == 0) ? wd0 : wd1) : 8'($urandom));
      wait_ack(wr ? "wr_byte" : "rd_byte");
    end
    @(posedge clk);
    #1;
    chk("end_sync", bus_sync_out, 1'b0);
    chk("end_busy", busy, 1'b0);
    chk("bus_q_empty", exp_bus.size(), 0);
    chk("mem_q_empty", exp_mem.size(), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  // Directed scenarios followed by randomised transactions
  initial begin
    logic [7:0]  h, s;
    logic [15:0] ad;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {bus_sync_out, bus_data_out, mem_req, mem_we, mem_seg_sel, mem_addr, mem_wdata, busy}, 0);
    rst_n = 1'b1;

    preload(24'h123400, 8'hAB);
    preload(24'h123401, 8'hCD);
    run_txn(8'h02, 8'h12, 16'h3400, 8'h00, 8'h00);
    run_txn(8'hC2, 8'h40, 16'h0010, 8'h5A, 8'h99);
    run_txn(8'h24, 8'h77, 16'hFFFE, 8'h00, 8'h00);
    mem_delay_fix = 6;
    run_txn(8'h00, 8'h21, 16'h1000, 8'h00, 8'h00);
    chk("req_len_delayed", last_req_len, 7);
    mem_delay_fix = -1;
    run_txn(8'hFA, 8'h05, 16'h0800, 8'h00, 8'h00);

    // Reset while the second write byte is waiting on memory
    for (int k = 0; k < 4; k++) push_bus(1'b0, 8'h00, 1'b1);
    push_bus(1'b0, 8'h00, 1'b1);
    exp_mem.push_back('{we: 1'b1, sel: 3'b001, addr: 24'h330200, wdata: 8'h11});
    exp_mem.push_back('{we: 1'b1, sel: 3'b001, addr: 24'h330201, wdata: 8'h22});
    ref_mem[24'h330200] = 8'h11;
    send_fast(8'h81, "hdr");
    send_fast(8'h33, "seg");
    send_fast(8'h02, "ahi");
    toggle(8'h00);
    wait_ack("alo");
    toggle(8'h11);
    wait_ack("wr_byte");
    mem_delay_fix = 5;
    toggle(8'h22);
    repeat (2) @(posedge clk);
    #1;
    chk("pre_reset_req", mem_req, 1'b1);
    rst_n = 1'b0;
    bus_sync_in = 1'b0;
    bus_data_in = 8'h00;
    #1;
    chk("reset_mid_outputs", {bus_sync_out, bus_data_out, mem_req, mem_we, mem_seg_sel, mem_addr, mem_wdata, busy}, 0);
    exp_bus.delete();
    exp_mem.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mem_delay_fix = -1;
    run_txn(8'h01, 8'h33, 16'h0200, 8'h00, 8'h00);

    for (int t = 0; t < 40; t++) begin
      h = 8'($urandom);
      s = 8'($urandom_range(3, 0));
      case ($urandom_range(2, 0))
        0:       ad = 16'hFFFC + 16'($urandom_range(3, 0));
        1:       ad = 16'($urandom_range(15, 0));
        default: ad = 16'($urandom);
      endcase
      run_txn(h, s, ad, 8'($urandom), 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
